// File: rtl/btb_control.sv
// rtl/btb_control.sv - update sequencer and address steering for the 4-way, 8-set BTB datapath
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   upd_valid/upd_ready      resolved-branch offer from writeback and FIFO acceptance
//   upd_taken/pc/target      resolved branch contents (not-taken transfers are dropped)
//   fetch_pc                 fetch-side lookup address used while IDLE
//   predict_valid/target     fetch prediction (gated off while an update owns the arrays)
//   busy                     sequencer active or updates pending
//   btb_pc_addr/wb_addr/old_pc_addr, wb_enable, wayN_write, lru_load   datapath controls
//   pc_hit, wb_hit, wb_compN_out, lru_out, btb_out                     datapath results

module btb_control #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic        upd_taken,
   input  logic [15:0] upd_pc,
   input  logic [15:0] upd_target,
   input  logic [15:0] fetch_pc,
   output logic        predict_valid,
   output logic [15:0] predict_target,
   output logic        busy,
   output logic [15:0] btb_pc_addr,
   output logic [15:0] btb_wb_addr,
   output logic [15:0] btb_old_pc_addr,
   output logic        wb_enable,
   output logic        way0_write,
   output logic        way1_write,
   output logic        way2_write,
   output logic        way3_write,
   output logic        lru_load,
   input  logic        pc_hit,
   input  logic        wb_hit,
   input  logic        wb_comp0_out,
   input  logic        wb_comp1_out,
   input  logic        wb_comp2_out,
   input  logic        wb_comp3_out,
   input  logic [2:0]  lru_out,
   input  logic [15:0] btb_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, LOOKUP, WRITE, TOUCH} state_t;

   state_t          state_q, state_d;
   logic            hit_q, hit_d;
   logic [1:0]      way_q, way_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [15:0]     mem_pc_q  [DEPTH];
   logic [15:0]     mem_tgt_q [DEPTH];

   logic            empty, full, push, pop;
   logic [15:0]     head_pc, head_tgt;
   logic [3:0]      wb_comp, way_wr;
   logic [1:0]      comp_way, victim_way;

   assign wb_comp  = {wb_comp3_out, wb_comp2_out, wb_comp1_out, wb_comp0_out};
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign head_pc  = mem_pc_q[rd_ptr_q];
   assign head_tgt = mem_tgt_q[rd_ptr_q];

   // The entry leaves the FIFO on the last cycle of its sequence.
   assign pop       = !rst && ((state_q == WRITE && hit_q) || state_q == TOUCH);
   assign upd_ready = rst || !full || pop;
   // Not-taken transfers complete the handshake but are never stored.
   assign push      = !rst && upd_valid && upd_ready && upd_taken;
   assign busy      = !rst && (state_q != IDLE || !empty);

   assign predict_target = btb_out;
   assign way0_write     = way_wr[0];
   assign way1_write     = way_wr[1];
   assign way2_write     = way_wr[2];
   assign way3_write     = way_wr[3];

   // Lowest-index matching way on a hit.
   always_comb begin
      comp_way = 2'd0;
      if (wb_comp[0])      comp_way = 2'd0;
      else if (wb_comp[1]) comp_way = 2'd1;
      else if (wb_comp[2]) comp_way = 2'd2;
      else if (wb_comp[3]) comp_way = 2'd3;
   end

   // Tree PLRU: bit0 picks the half, bit1/bit2 pick within the lower/upper half.
   always_comb begin
      victim_way = 2'd0;
      if (!lru_out[0]) victim_way = {1'b0, lru_out[1]};
      else             victim_way = {1'b1, lru_out[2]};
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_comb begin
      state_d         = state_q;
      hit_d           = hit_q;
      way_d           = way_q;
      btb_pc_addr     = fetch_pc;
      btb_old_pc_addr = fetch_pc;
      btb_wb_addr     = fetch_pc;
      predict_valid   = 1'b0;
      wb_enable       = 1'b0;
      lru_load        = 1'b0;
      way_wr          = 4'b0000;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               predict_valid = pc_hit;
               // Leaving on the push itself gives LOOKUP one cycle after acceptance.
               if (!empty || push) state_d = LOOKUP;
            end
            LOOKUP: begin
               btb_pc_addr     = head_pc;
               btb_old_pc_addr = head_pc;
               btb_wb_addr     = head_pc;
               wb_enable       = 1'b1;
               hit_d           = wb_hit;
               way_d           = wb_hit ? comp_way : victim_way;
               lru_load        = wb_hit;
               state_d         = WRITE;
            end
            WRITE: begin
               btb_pc_addr     = head_pc;
               btb_old_pc_addr = head_pc;
               btb_wb_addr     = head_tgt;
               wb_enable       = 1'b1;
               way_wr[way_q]   = 1'b1;
               state_d         = hit_q ? IDLE : TOUCH;
            end
            TOUCH: begin
               // The new entry now matches, so the LRU logic records its way.
               btb_pc_addr     = head_pc;
               btb_old_pc_addr = head_pc;
               btb_wb_addr     = head_pc;
               wb_enable       = 1'b1;
               lru_load        = 1'b1;
               state_d         = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hit_q    <= 1'b0;
         way_q    <= 2'd0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         hit_q    <= hit_d;
         way_q    <= way_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) begin
            mem_pc_q[wr_ptr_q]  <= upd_pc;
            mem_tgt_q[wr_ptr_q] <= upd_target;
         end
      end
   end

endmodule
